// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Purpose : Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      fnc3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      rd_i,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [2:0]        r_fnc3;
  logic [4:0]        r_rd;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;

  // Operand decode at launch
  logic            w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_ovf, w_special, w_launch;
  logic [XLEN-1:0] w_special_res;

  assign w_a_signed = (fnc3 == 3'b001) || (fnc3 == 3'b010) ||
                      (fnc3 == 3'b100) || (fnc3 == 3'b110);
  assign w_b_signed = (fnc3 == 3'b001) || (fnc3 == 3'b100) || (fnc3 == 3'b110);
  assign w_sa       = w_a_signed & opa[XLEN-1];
  assign w_sb       = w_b_signed & opb[XLEN-1];
  assign w_mag_a    = w_sa ? -opa : opa;
  assign w_mag_b    = w_sb ? -opb : opb;
  // Remainder takes the dividend's sign; everything else the product/quotient sign
  assign w_neg      = (fnc3 == 3'b110) ? w_sa : (w_sa ^ w_sb);

  assign w_div_zero = fnc3[2] && (opb == '0);
  assign w_ovf      = ((fnc3 == 3'b100) || (fnc3 == 3'b110)) &&
                      (opa == MIN_NEG) && (opb == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_launch   = (r_state == S_IDLE) && start && !flush;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = fnc3[1] ? opa : '1;
    else if (!fnc3[1])
      w_special_res = MIN_NEG;
  end

  // One iteration: accumulator high half is partial product / remainder,
  // low half is multiplier / quotient being shifted in.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_shift, w_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;

  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  assign w_shift    = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_div_next = w_diff[XLEN] ?
                      {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                      {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  assign w_acc_next = r_fnc3[2] ? w_div_next : w_mul_next;

  // Final sign correction and result selection
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;

  assign w_prod_fix = r_neg ? -w_acc_next : w_acc_next;
  assign w_quo_fix  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem_fix  = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_fnc3)
      3'b000:                 w_final = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo_fix;
      default:                w_final = w_rem_fix;
    endcase
  end

  // State machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start && !flush) w_state_next = w_special ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (flush)              w_state_next = S_IDLE;
        else if (r_cnt == LAST) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign stall = !rst && (w_launch || (r_state == S_BUSY));

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fnc3 <= '0;
      r_rd   <= '0;
      r_neg  <= 1'b0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      result <= '0;
      rd_o   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_fnc3 <= fnc3;
            r_rd   <= rd_i;
            r_neg  <= w_neg;
            r_cnt  <= '0;
            r_b    <= fnc3[2] ? w_mag_b : w_mag_a;
            r_acc  <= {{XLEN{1'b0}}, (fnc3[2] ? w_mag_a : w_mag_b)};
            if (w_special) begin
              result <= w_special_res;
              rd_o   <= rd_i;
              done   <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (!flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              result <= w_final;
              rd_o   <= r_rd;
              done   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Purpose : Directed self-checking bench for muldiv_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  fnc3 = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [4:0]  rd_i = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_o;

  int n_pass = 0;
  int n_total = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fnc3   (fnc3),
    .opa    (opa),
    .opb    (opb),
    .rd_i   (rd_i),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_o   (rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at posedge+2 of a cycle with the unit idle. Holds start until the
  // done pulse, then drops it in the following cycle and checks nothing relaunched.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_cyc);
    int cyc = 0;
    int nst = 0;
    fnc3 = f; opa = a; opb = b; rd_i = rd; start = 1'b1;
    #1;
    while (!done && cyc < 200) begin
      if (stall) nst++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_stall_cycles"}, nst, exp_cyc);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
    chk({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk({tag, "_no_relaunch"}, {30'd0, stall, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {stall, done, rd_o, result[24:0]}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    run_op("mul_neg",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
    run_op("mulhu",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33);
    run_op("mulh",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33);
    run_op("mulhsu",     3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run_op("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
    run_op("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
    run_op("divu",       3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33);
    run_op("remu",       3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
    run_op("divu_zero",  3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
    run_op("remu_zero",  3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);

    // Back-to-back: second op launches in the cycle right after DONE
    run_op("b2b_first",  3'b000, 32'd2,        32'd3,        5'd17, 32'd6,        33);
    run_op("b2b_second", 3'b000, 32'd5,        32'd6,        5'd18, 32'd30,       33);

    // Flush while idle suppresses launch
    fnc3 = 3'b000; opa = 32'd9; opb = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #2;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_no_launch", {30'd0, stall, done}, 32'd0);
    @(posedge clk); #2;

    // Asynchronous reset in the middle of BUSY iteration 10
    fnc3 = 3'b000; opa = 32'd11; opb = 32'd13; rd_i = 5'd19; start = 1'b1;
    repeat (11) @(posedge clk);
    #3;
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {25'd0, stall, done, rd_o}, 32'd0);
    chk("async_reset_result", result, 32'd0);
    start = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd20, 32'd12, 33);

    // Flush during BUSY iteration 5: no done pulse, stall drops next cycle
    begin
      int pulses = 0;
      fnc3 = 3'b000; opa = 32'd21; opb = 32'd2; rd_i = 5'd21; start = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      flush = 1'b1;
      start = 1'b0;
      @(posedge clk); #2;
      flush = 1'b0;
      #1;
      chk("flush_busy_stall_low", {31'd0, stall}, 32'd0);
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done) pulses++;
      end
      chk("flush_busy_no_done", pulses, 32'd0);
      chk("flush_busy_result_held", result, 32'd12);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
